packet_router_np: RTL and testbench
===================================

PACKET_ROUTER_NP -- requirements
Module: packet_router_np

Interface
REQ-001 SHALL have parameter NPORTS, default 4, number of output ports (2..8).
REQ-002 SHALL have parameter DW, default 8, data/address byte width.
REQ-003 SHALL have parameter DEPTH, default 16, per-port FIFO entries (power of 2).
REQ-004 SHALL have parameter BCAST, default all-ones (DW bits), broadcast destination address.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 data  input  DW  packet byte stream.
REQ-008 data_status  input  1  high while a packet is being presented; first high cycle carries header.
REQ-009 fifo_full  output  1  backpressure; source SHALL hold current byte while high.
REQ-010 mem_en / mem_rd_wr  input  1 / 1  config access enable; 1=write, 0=read.
REQ-011 mem_add  input  $clog2(NPORTS)  config register index (port number).
REQ-012 mem_data / mem_rdata  input / output  DW / DW  config write data / read data.
REQ-013 port[NPORTS]  output  DW each  popped byte per port.
REQ-014 ready[NPORTS] / read[NPORTS]  output / input  1 each  FIFO non-empty / pop request.
REQ-015 drop_cnt  output  16  count of dropped packets.
REQ-016 parity_err  output  1  one-cycle pulse on bad packet parity.

Function
REQ-017 Config write (mem_en&mem_rd_wr) SHALL load addr_reg[mem_add]; read SHALL drive mem_rdata=addr_reg[mem_add] one cycle later; writes take effect at next header decode.
REQ-018 Packet format: header (dest address), payload bytes, final parity byte; packet ends when data_status falls.
REQ-019 FSM states IDLE, FORWARD, DROP; IDLE->decode on data_status high.
REQ-020 Decode: target mask = all ports with addr_reg==header; header==BCAST targets all ports.
REQ-021 Non-empty mask SHALL go FORWARD and write header into every targeted FIFO; empty mask SHALL go DROP.
REQ-022 FORWARD: each accepted byte (data_status high, fifo_full low) SHALL be written to all targeted FIFOs same cycle.
REQ-023 fifo_full SHALL be combinational OR of full flags of targeted FIFOs (in IDLE: OR of all FIFOs); no FIFO SHALL be written while high.
REQ-024 DROP: bytes consumed and discarded, fifo_full low; drop_cnt increments once per dropped packet, saturating at 16'hFFFF.
REQ-025 data_status low in FORWARD or DROP SHALL return to IDLE next cycle; back-to-back packets need one idle cycle.
REQ-026 Running XOR of all accepted bytes incl. header and parity SHALL be nonzero -> parity_err pulse the cycle after packet end; packet data is still delivered.
REQ-027 ready[i] SHALL equal FIFO i non-empty; read[i]&ready[i] pops and registers port[i] one cycle later; read on empty ignored, port[i] holds.
REQ-028 Simultaneous push and pop on a full FIFO: full evaluated before pop, push blocked that cycle.
REQ-029 Simultaneous push and pop on non-full FIFO SHALL leave occupancy unchanged; pointers wrap modulo DEPTH.

Reset
REQ-030 Reset SHALL force FSM IDLE, flush all FIFOs (ready all 0), port[*]=0, mem_rdata=0, drop_cnt=0, parity_err=0, fifo_full=0.
REQ-031 Reset SHALL set addr_reg[i]=i; reset mid-packet SHALL abandon the packet with no further writes.

Structure
REQ-032 Package router_pkg SHALL hold state enum (IDLE, FORWARD, DROP) and default parameter constants.
REQ-033 Per-port FIFO SHALL be sub-module router_fifo (DW, DEPTH), instantiated NPORTS times via generate.

Verification
REQ-034 Addr_reg[2]=8'h05; packet 05,AA,BB,parity 14 -> port2 pops 05,AA,BB,14; parity_err 0; other ready low.
REQ-035 Header 8'hFF, 3 bytes -> all NPORTS FIFOs hold identical 4 bytes.
REQ-036 Header 8'h77 unmatched -> no FIFO writes, drop_cnt 0->1, fifo_full low throughout.
REQ-037 Fill port1 FIFO to DEPTH, send packet to port1 -> fifo_full high, byte held; one read[1] -> byte accepted next cycle.
REQ-038 Packet 00,11 with bad parity 8'h00 -> delivered to port0, parity_err pulse one cycle after data_status falls.
REQ-039 Reset asserted mid-packet -> all ready 0, port outputs 0, next packet routed normally after release.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and default sizing for the packet router.
//   state_t     : header-decode FSM states
//   DEF_*       : default parameter values for the router and its FIFOs
package router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_DEPTH  = 16;

endpackage

// File: rtl/router_fifo.sv
// Per-port synchronous FIFO with registered read data.
//   clk      : clock, rising edge
//   i_rst_n  : asynchronous active-low reset (flushes, clears o_dout)
//   i_push   : write i_din (ignored while o_full)
//   i_din    : write data
//   i_pop    : read request (ignored while o_empty); o_dout updates next cycle
//   o_dout   : last popped byte, held between pops
//   o_full   : DEPTH entries stored
//   o_empty  : no entries stored
module router_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_din,
  input  logic          i_pop,
  output logic [DW-1:0] o_dout,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Full is judged on current occupancy, so a pop in the same cycle
  // does not make room for a push.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_dout   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        o_dout   <= r_mem[r_rd_ptr[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/packet_router_np.sv
// Multi-port packet router: decodes a header byte against per-port address
// registers and copies the packet into every matching port FIFO.
//   clk, reset              : clock (rising edge), async active-low reset
//   data, data_status       : byte stream; first high cycle is the header
//   fifo_full               : backpressure, source holds byte while high
//   mem_en/mem_rd_wr/mem_add: address-register access (1=write, 0=read)
//   mem_data/mem_rdata      : write data / registered read data
//   port[i], ready[i], read[i]: per-port pop interface
//   drop_cnt                : saturating count of dropped packets
//   parity_err              : one-cycle pulse after a packet with bad parity
module packet_router_np
  import router_pkg::*;
#(
  parameter int            NPORTS = DEF_NPORTS,
  parameter int            DW     = DEF_DW,
  parameter int            DEPTH  = DEF_DEPTH,
  parameter logic [DW-1:0] BCAST  = '1,
  localparam int           AW     = $clog2(NPORTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DW-1:0]     data,
  input  logic              data_status,
  output logic              fifo_full,
  input  logic              mem_en,
  input  logic              mem_rd_wr,
  input  logic [AW-1:0]     mem_add,
  input  logic [DW-1:0]     mem_data,
  output logic [DW-1:0]     mem_rdata,
  output logic [DW-1:0]     port [NPORTS],
  output logic [NPORTS-1:0] ready,
  input  logic [NPORTS-1:0] read,
  output logic [15:0]       drop_cnt,
  output logic              parity_err
);

  state_t              r_state;
  state_t              w_next;
  logic [DW-1:0]       r_addr [NPORTS];
  logic [NPORTS-1:0]   r_mask;
  logic [DW-1:0]       r_parity;
  logic [NPORTS-1:0]   w_match;
  logic [NPORTS-1:0]   w_full;
  logic [NPORTS-1:0]   w_empty;
  logic [NPORTS-1:0]   w_push;
  logic [NPORTS-1:0]   w_pop;
  logic                w_accept;
  logic                w_hdr_fwd;
  logic                w_hdr_drop;
  logic                w_end;

  // Address registers and config readback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NPORTS; i++) begin
        r_addr[i] <= DW'(i);
      end
      mem_rdata <= '0;
    end else if (mem_en && (int'(mem_add) < NPORTS)) begin
      if (mem_rd_wr) begin
        r_addr[mem_add] <= mem_data;
      end else begin
        mem_rdata <= r_addr[mem_add];
      end
    end
  end

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      w_match[i] = (data == BCAST) || (r_addr[i] == data);
    end
  end

  // In IDLE the destination is not yet known, so any full FIFO stalls the header.
  always_comb begin
    fifo_full = 1'b0;
    case (r_state)
      ST_IDLE:    fifo_full = |w_full;
      ST_FORWARD: fifo_full = |(w_full & r_mask);
      default:    fifo_full = 1'b0;
    endcase
  end

  assign w_accept = data_status && !fifo_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_push     = '0;
    w_hdr_fwd  = 1'b0;
    w_hdr_drop = 1'b0;
    w_end      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (|w_match) begin
            w_next    = ST_FORWARD;
            w_push    = w_match;
            w_hdr_fwd = 1'b1;
          end else begin
            w_next     = ST_DROP;
            w_hdr_drop = 1'b1;
          end
        end
      end
      ST_FORWARD: begin
        if (!data_status) begin
          w_next = ST_IDLE;
          w_end  = 1'b1;
        end else if (w_accept) begin
          w_push = r_mask;
        end
      end
      ST_DROP: begin
        if (!data_status) begin
          w_next = ST_IDLE;
          w_end  = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Packet bookkeeping: target mask, running parity, drop count, error pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mask     <= '0;
      r_parity   <= '0;
      drop_cnt   <= '0;
      parity_err <= 1'b0;
    end else begin
      if (w_hdr_fwd) begin
        r_mask <= w_match;
      end
      if (w_accept) begin
        r_parity <= (r_state == ST_IDLE) ? data : (r_parity ^ data);
      end
      if (w_hdr_drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
      parity_err <= w_end && (r_parity != '0);
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_port
    assign ready[g] = ~w_empty[g];
    assign w_pop[g] = read[g] & ~w_empty[g];

    router_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .i_rst_n (reset),
      .i_push  (w_push[g]),
      .i_din   (data),
      .i_pop   (w_pop[g]),
      .o_dout  (port[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

endmodule

// File: tb/tb_packet_router_np.sv
// Directed self-checking bench for packet_router_np (default parameters).
module tb_packet_router_np;

  localparam int NP = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data;
  logic          data_status;
  logic          fifo_full;
  logic          mem_en;
  logic          mem_rd_wr;
  logic [1:0]    mem_add;
  logic [DW-1:0] mem_data;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] port [NP];
  logic [NP-1:0] ready;
  logic [NP-1:0] read;
  logic [15:0]   drop_cnt;
  logic          parity_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  packet_router_np #(
    .NPORTS (NP),
    .DW     (DW),
    .DEPTH  (16),
    .BCAST  (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .data        (data),
    .data_status (data_status),
    .fifo_full   (fifo_full),
    .mem_en      (mem_en),
    .mem_rd_wr   (mem_rd_wr),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .mem_rdata   (mem_rdata),
    .port        (port),
    .ready       (ready),
    .read        (read),
    .drop_cnt    (drop_cnt),
    .parity_err  (parity_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    mem_en = 1'b1; mem_rd_wr = 1'b1; mem_add = a; mem_data = d;
    tick();
    mem_en = 1'b0;
  endtask

  task automatic cfg_read_check(input logic [1:0] a, input logic [7:0] exp, input string tag);
    mem_en = 1'b1; mem_rd_wr = 1'b0; mem_add = a;
    tick();
    mem_en = 1'b0;
    check(tag, mem_rdata, exp);
  endtask

  // Presents each byte until accepted; returns the parity_err value seen
  // in the cycle after data_status falls and checks that it is a pulse.
  task automatic send_pkt(input logic [7:0] pk[$], input bit no_full, output logic perr);
    int guard;
    foreach (pk[k]) begin
      data = pk[k];
      data_status = 1'b1;
      #1;
      if (no_full) check("fifo_full_drop", fifo_full, 0);
      guard = 0;
      while (fifo_full && guard < 200) begin
        tick();
        #1;
        guard++;
      end
      if (guard >= 200) check("send_timeout", 0, 1);
      tick();
    end
    data_status = 1'b0;
    tick();
    perr = parity_err;
    tick();
    check("perr_pulse_end", parity_err, 0);
  endtask

  task automatic pop_expect(input int p, input logic [7:0] q[$], input string tag);
    foreach (q[k]) begin
      read[p] = 1'b1;
      tick();
      read[p] = 1'b0;
      check(tag, port[p], q[k]);
    end
  endtask

  logic [7:0] pk[$];
  logic [7:0] q1[$];
  logic [7:0] par;
  logic       perr;

  initial begin
    reset = 1'b0; data = '0; data_status = 1'b0;
    mem_en = 1'b0; mem_rd_wr = 1'b0; mem_add = '0; mem_data = '0; read = '0;
    tick(); tick();

    // Reset state
    check("rst_ready", ready, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    for (int i = 0; i < NP; i++) check("rst_port", port[i], 0);
    reset = 1'b1;
    tick();
    cfg_read_check(2'd3, 8'h03, "rst_addr3");

    // Unicast to port 2 after reprogramming its address
    cfg_write(2'd2, 8'h05);
    cfg_read_check(2'd2, 8'h05, "cfg_addr2");
    pk = {8'h05, 8'hAA, 8'hBB, 8'h14};
    send_pkt(pk, 1'b0, perr);
    check("uni_perr", perr, 0);
    check("uni_ready", ready, 4'b0100);
    pop_expect(2, pk, "uni_port2");
    check("uni_ready_empty", ready, 0);

    // Broadcast
    pk = {8'hFF, 8'h01, 8'h02, 8'hFC};
    send_pkt(pk, 1'b0, perr);
    check("bc_perr", perr, 0);
    check("bc_ready", ready, 4'hF);
    for (int p = 0; p < NP; p++) pop_expect(p, pk, "bc_port");
    check("bc_ready_empty", ready, 0);

    // Unmatched header is dropped
    pk = {8'h77, 8'h12, 8'h65};
    send_pkt(pk, 1'b1, perr);
    check("drop_cnt", drop_cnt, 1);
    check("drop_ready", ready, 0);

    // Bad parity still delivered, with an error pulse
    pk = {8'h00, 8'h11, 8'h00};
    send_pkt(pk, 1'b0, perr);
    check("bad_perr", perr, 1);
    check("bad_ready", ready, 4'b0001);
    pop_expect(0, pk, "bad_port0");

    // Fill port 1 to 16 entries
    q1 = {8'h01};
    par = 8'h01;
    for (int i = 0; i < 14; i++) begin
      q1.push_back(8'h20 + 8'(i));
      par ^= 8'h20 + 8'(i);
    end
    q1.push_back(par);
    send_pkt(q1, 1'b0, perr);
    check("fill_perr", perr, 0);
    check("fill_ready", ready, 4'b0010);
    check("fill_full_idle", fifo_full, 1);

    // Header for port 1 is held until a pop frees a slot
    data = 8'h01; data_status = 1'b1;
    #1;
    check("hold_full", fifo_full, 1);
    tick(); tick();
    check("hold_still_full", fifo_full, 1);
    read[1] = 1'b1;
    tick();
    read[1] = 1'b0;
    check("hold_pop", port[1], 8'h01);
    check("hold_released", fifo_full, 0);
    tick();
    // Header accepted; FIFO full again for each following byte
    pk = {8'h5A, 8'h5B};
    foreach (pk[k]) begin
      data = pk[k];
      #1;
      check("fwd_full", fifo_full, 1);
      read[1] = 1'b1;
      tick();
      read[1] = 1'b0;
      check("fwd_pop", port[1], (k == 0) ? 8'h20 : 8'h21);
      check("fwd_released", fifo_full, 0);
      tick();
    end
    data_status = 1'b0;
    tick();
    check("full_pkt_perr", parity_err, 0);
    tick();
    q1 = q1[3:$];
    q1.push_back(8'h01);
    q1.push_back(8'h5A);
    q1.push_back(8'h5B);
    pop_expect(1, q1, "drain_port1");
    check("drain_ready", ready, 0);

    // Reset mid-packet
    data = 8'h03; data_status = 1'b1;
    tick();
    data = 8'h44;
    tick();
    check("mid_ready_pre", ready, 4'b1000);
    reset = 1'b0;
    #1;
    check("mid_ready", ready, 0);
    check("mid_fifo_full", fifo_full, 0);
    check("mid_drop_cnt", drop_cnt, 0);
    for (int i = 0; i < NP; i++) check("mid_port", port[i], 0);
    data_status = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    cfg_read_check(2'd2, 8'h02, "mid_addr2");
    pk = {8'h02, 8'h33, 8'h31};
    send_pkt(pk, 1'b0, perr);
    check("post_perr", perr, 0);
    check("post_ready", ready, 4'b0100);
    pop_expect(2, pk, "post_port2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
